// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width, bit-counter sizing.
// No logic; no latency or flow control of its own.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_e;

    function automatic int uart_cnt_width(input int clkdiv);
        return (clkdiv <= 2) ? 1 : $clog2(clkdiv);
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for one asynchronous input, reset to RST_VAL.
// Latency 2 cycles; no flow control.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: one byte per good frame, stop-bit errors flagged.
// Latency: pulse 2+HALF+9*CLKDIV cycles after the start edge; no backpressure, data held until next good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKDIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      received,
    output logic                      frame_err
);

    localparam int CW   = uart_cnt_width(CLKDIV);
    localparam int HALF = CLKDIV / 2;
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    if (CLKDIV < 4) begin : g_bad_clkdiv
        $error("uart_rx: CLKDIV must be at least 4");
    end

    logic rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    uart_state_e               state_q;
    logic [CW-1:0]             cnt_q;
    logic [2:0]                idx_q;
    logic [UART_DATA_BITS-1:0] sh_q;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      received_q;
    logic                      frame_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            data_q      <= '0;
            received_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            received_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    // A low shorter than half a bit is treated as a glitch.
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= ST_DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        sh_q  <= {rx_s, sh_q[UART_DATA_BITS-1:1]};
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop-bit gives margin for zero-gap frames.
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q     <= sh_q;
                            received_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign received  = received_q;
    assign frame_err = frame_err_q;

endmodule
